sine_phase_addr_gen: RTL and testbench
======================================

Name: sine_phase_addr_gen

Overview:
- Upstream address generator for the dual-port sine ROM.
- Uses a fractional phase accumulator to produce two ROM addresses:
  - addr1 is the accumulator phase.
  - addr2 is addr1 plus a programmable phase offset.
- New frequency and offset values are held in shadow registers and applied at accumulator wrap, so output phase stays continuous.
- Outputs are registered and drive the ROM address ports directly.

Parameters:
- ADDRESS_WIDTH, 8, ROM address width; width of addr1, addr2 and offset.
- FRAC_WIDTH, 8, fractional bits in the accumulator below the address bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  accumulator advance enable.
- load  input  1  single-cycle request to capture incr and offset into the shadow registers.
- incr  input  ADDRESS_WIDTH+FRAC_WIDTH  phase step per enabled cycle; unsigned, fixed-point.
- offset  input  ADDRESS_WIDTH  phase offset of addr2 relative to addr1, in ROM entries.
- addr1  output  ADDRESS_WIDTH  ROM address port 1.
- addr2  output  ADDRESS_WIDTH  ROM address port 2.
- wrap  output  1  one-cycle pulse marking that the accumulator overflowed on the last edge.
- pending  output  1  shadow values are captured but not yet active.

Behaviour:
- Internal state:
  - acc, ADDRESS_WIDTH+FRAC_WIDTH bits.
  - incr_act / off_act, the active values.
  - incr_sh / off_sh, the shadow values.
- Reset, asynchronous, takes effect immediately without a clock edge:
  - acc=0, incr_act=2**FRAC_WIDTH (one address per cycle), off_act=0.
  - Shadows are 0.
  - addr1=0, addr2=0, wrap=0, pending=0.
- Accumulation, on each edge with en=1:
  - sum = acc + incr_act, computed one bit wider.
  - acc <= sum modulo 2**(ADDRESS_WIDTH+FRAC_WIDTH).
  - wrap <= carry out of sum.
- When en=0: acc holds and wrap <= 0.
- Address outputs, registered on the same edge as acc (zero added latency relative to acc):
  - addr1 <= upper ADDRESS_WIDTH bits of the next acc.
  - addr2 <= (those bits + off_act) modulo 2**ADDRESS_WIDTH.
- The ROM adds its own one-cycle read latency downstream.
- States:
  - IDLE (pending=0).
  - PEND (pending=1).
- Transitions:
  - IDLE + load: incr_sh <= incr, off_sh <= offset, go to PEND.
  - PEND + load, with no commit this edge: shadows are overwritten and the state stays PEND.
  - PEND commits when any of the following holds on an edge: en=0, incr_act==0, or the carry is set.
  - On commit: incr_act <= incr_sh, off_act <= off_sh, go to IDLE.
  - The commit edge itself still accumulates and forms addr2 with the old values; new values take effect from the next edge.
  - Commit on en=0 therefore occurs on the first edge after entering PEND.
- Simultaneous load and commit edge:
  - The incoming incr/offset are committed directly to the active registers, bypassing the shadows.
  - Go to IDLE; pending=0.
- incr=0 is legal: addresses freeze and wrap never fires.
- Only an acc overflow produces wrap. Reaching addr1==0 without a carry does not.

Test Plan:
- Default step:
  - Stimulus: release reset, en=1, no load.
  - Required: addr1=addr2 stepping 0,1,2,3...; wrap is high exactly in the cycle addr1 returns to 0x00, after 256 enabled edges.
- Stopped load:
  - Stimulus: en=0, load with incr=0x0080, offset=0x40.
  - Required: pending=1 for exactly one cycle, then 0.
  - Then en=1: addr1 steps 0,0,1,1,2...; addr2=addr1+0x40 mod 256 (addr1=0xC0 gives addr2=0x00).
- Phase-continuous update:
  - Stimulus: running at incr=0x0100; at addr1=0x10, load incr=0x0400.
  - Required: pending stays 1 while addr1 steps by 1 through 0xFF to 0x00 with wrap=1; then pending=0 and addr1 steps 0x04, 0x08...
- Fractional step:
  - Stimulus: incr=0x0180 from acc=0.
  - Required: addr1 sequence 0x00,0x01,0x03,0x04,0x06; wrap on the edge where acc passes 0xFFFF.
- Simultaneous load on wrap edge:
  - Stimulus: load offset=0x80, incr=0x0200 on the same edge that carries.
  - Required: pending never rises; the next edge has addr1 step 2 and addr2=addr1+0x80.
- Asynchronous reset mid-run:
  - Stimulus: assert rst_n=0 between clock edges while pending=1.
  - Required: addr1, addr2, wrap and pending read 0 immediately; after release, addr1 steps 0,1,2 (default incr restored).

Source files
------------

// File: rtl/sine_phase_addr_gen.sv
// Phase-accumulator address generator for a dual-port sine ROM.
// addr1 is the integer part of the accumulator phase; addr2 is addr1 plus a
// programmable offset. New step/offset values are staged in shadow registers
// and activated at a phase-safe point so the output phase stays continuous.
module sine_phase_addr_gen #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int FRAC_WIDTH    = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                en,
   input  logic                                load,
   input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] incr,
   input  logic [ADDRESS_WIDTH-1:0]            offset,
   output logic [ADDRESS_WIDTH-1:0]            addr1,
   output logic [ADDRESS_WIDTH-1:0]            addr2,
   output logic                                wrap,
   output logic                                pending
);

   localparam int ACC_W = ADDRESS_WIDTH + FRAC_WIDTH;
   // One ROM entry per enabled cycle out of reset.
   localparam logic [ACC_W-1:0] INCR_RST = {{(ACC_W-1){1'b0}}, 1'b1} << FRAC_WIDTH;

   typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

   state_e                   state_q, state_d;
   logic [ACC_W-1:0]         acc_q, acc_d;
   logic [ACC_W-1:0]         incr_act_q, incr_act_d;
   logic [ACC_W-1:0]         incr_sh_q, incr_sh_d;
   logic [ADDRESS_WIDTH-1:0] off_act_q, off_act_d;
   logic [ADDRESS_WIDTH-1:0] off_sh_q, off_sh_d;
   logic [ADDRESS_WIDTH-1:0] addr1_q, addr1_d;
   logic [ADDRESS_WIDTH-1:0] addr2_q, addr2_d;
   logic                     wrap_q, wrap_d;
   logic [ACC_W:0]           sum;
   logic                     carry;
   logic                     commit_ok;

   // Next-state: accumulate, form addresses with the currently active values,
   // and decide when staged values may become active.
   always_comb begin
      sum        = {1'b0, acc_q} + {1'b0, incr_act_q};
      carry      = en & sum[ACC_W];
      acc_d      = en ? sum[ACC_W-1:0] : acc_q;
      wrap_d     = carry;
      addr1_d    = acc_d[ACC_W-1:FRAC_WIDTH];
      addr2_d    = addr1_d + off_act_q;
      // Safe to swap values when stopped, frozen, or exactly at phase wrap.
      commit_ok  = !en || (incr_act_q == '0) || carry;
      state_d    = state_q;
      incr_act_d = incr_act_q;
      off_act_d  = off_act_q;
      incr_sh_d  = incr_sh_q;
      off_sh_d   = off_sh_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               if (carry) begin
                  // Load lands on the wrap edge itself: no need to wait for
                  // the next wrap, take the new values straight away.
                  incr_act_d = incr;
                  off_act_d  = offset;
               end else begin
                  incr_sh_d = incr;
                  off_sh_d  = offset;
                  state_d   = PEND;
               end
            end
         end
         PEND: begin
            if (commit_ok) begin
               // A load on the commit edge is newer than the shadows; bypass them.
               incr_act_d = load ? incr   : incr_sh_q;
               off_act_d  = load ? offset : off_sh_q;
               state_d    = IDLE;
            end else if (load) begin
               incr_sh_d = incr;
               off_sh_d  = offset;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         incr_act_q <= INCR_RST;
         off_act_q  <= '0;
         incr_sh_q  <= '0;
         off_sh_q   <= '0;
         addr1_q    <= '0;
         addr2_q    <= '0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         incr_act_q <= incr_act_d;
         off_act_q  <= off_act_d;
         incr_sh_q  <= incr_sh_d;
         off_sh_q   <= off_sh_d;
         addr1_q    <= addr1_d;
         addr2_q    <= addr2_d;
         wrap_q     <= wrap_d;
      end
   end

   assign addr1   = addr1_q;
   assign addr2   = addr2_q;
   assign wrap    = wrap_q;
   assign pending = (state_q == PEND);

endmodule

// File: tb/tb_sine_phase_addr_gen.sv
// Directed bench for sine_phase_addr_gen (ADDRESS_WIDTH=8, FRAC_WIDTH=8).
module tb_sine_phase_addr_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [15:0] incr = '0;
   logic [7:0]  offset = '0;
   logic [7:0]  addr1, addr2;
   logic        wrap, pending;

   int checks = 0;
   int errors = 0;

   sine_phase_addr_gen #(.ADDRESS_WIDTH(8), .FRAC_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .incr(incr),
      .offset(offset), .addr1(addr1), .addr2(addr2), .wrap(wrap),
      .pending(pending)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; load = 1'b0;
      #12;
      checks++; if (addr1 !== 8'h00) begin errors++; $display("FAIL reset_addr1 got %h want 00", addr1); end
      checks++; if (addr2 !== 8'h00) begin errors++; $display("FAIL reset_addr2 got %h want 00", addr2); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", pending); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_default_step();
      logic [7:0] e;
      en = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         tick();
         e = 8'(i);
         checks++; if (addr1 !== e) begin errors++; $display("FAIL dflt_addr1 step %0d got %h want %h", i, addr1, e); end
         checks++; if (addr2 !== e) begin errors++; $display("FAIL dflt_addr2 step %0d got %h want %h", i, addr2, e); end
         checks++; if (wrap !== (i == 256)) begin errors++; $display("FAIL dflt_wrap step %0d got %b want %b", i, wrap, (i == 256)); end
      end
   endtask

   task automatic test_stopped_load();
      logic [7:0] e1, e2;
      en = 1'b0; load = 1'b1; incr = 16'h0080; offset = 8'h40;
      tick();
      load = 1'b0;
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL stop_pend_hi got %b want 1", pending); end
      tick();
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL stop_pend_lo got %b want 0", pending); end
      checks++; if (addr1 !== 8'h00) begin errors++; $display("FAIL stop_hold_addr1 got %h want 00", addr1); end
      en = 1'b1;
      for (int k = 1; k <= 512; k++) begin
         tick();
         e1 = 8'((k / 2) % 256);
         e2 = e1 + 8'h40;
         checks++; if (addr1 !== e1) begin errors++; $display("FAIL half_addr1 k=%0d got %h want %h", k, addr1, e1); end
         checks++; if (addr2 !== e2) begin errors++; $display("FAIL half_addr2 k=%0d got %h want %h", k, addr2, e2); end
         checks++; if (wrap !== (k == 512)) begin errors++; $display("FAIL half_wrap k=%0d got %b want %b", k, wrap, (k == 512)); end
      end
   endtask

   task automatic test_phase_continuous();
      logic [7:0] e;
      // restore unit step, zero offset while stopped
      en = 1'b0; load = 1'b1; incr = 16'h0100; offset = 8'h00;
      tick(); load = 1'b0; tick();
      en = 1'b1;
      for (int k = 1; k <= 16; k++) tick();
      checks++; if (addr1 !== 8'h10) begin errors++; $display("FAIL pc_start got %h want 10", addr1); end
      load = 1'b1; incr = 16'h0400;
      tick();
      load = 1'b0;
      for (int a = 8'h11; a <= 8'hFF; a++) begin
         e = 8'(a);
         checks++; if (addr1 !== e || pending !== 1'b1 || wrap !== 1'b0) begin
            errors++; $display("FAIL pc_hold got addr1=%h pend=%b wrap=%b want %h/1/0", addr1, pending, wrap, e);
         end
         tick();
      end
      checks++; if (addr1 !== 8'h00 || wrap !== 1'b1 || pending !== 1'b0) begin
         errors++; $display("FAIL pc_wrap got addr1=%h wrap=%b pend=%b want 00/1/0", addr1, wrap, pending);
      end
      tick();
      checks++; if (addr1 !== 8'h04) begin errors++; $display("FAIL pc_step1 got %h want 04", addr1); end
      tick();
      checks++; if (addr1 !== 8'h08) begin errors++; $display("FAIL pc_step2 got %h want 08", addr1); end
   endtask

   task automatic test_fractional();
      logic [7:0] e;
      int acc;
      rst_n = 1'b0; en = 1'b0; #3; rst_n = 1'b1;
      load = 1'b1; incr = 16'h0180; offset = 8'h00;
      tick(); load = 1'b0; tick();
      checks++; if (addr1 !== 8'h00) begin errors++; $display("FAIL frac_start got %h want 00", addr1); end
      en = 1'b1;
      for (int k = 1; k <= 171; k++) begin
         tick();
         acc = (k * 384) % 65536;
         e = 8'(acc / 256);
         checks++; if (addr1 !== e) begin errors++; $display("FAIL frac_addr1 k=%0d got %h want %h", k, addr1, e); end
         checks++; if (wrap !== (k == 171)) begin errors++; $display("FAIL frac_wrap k=%0d got %b want %b", k, wrap, (k == 171)); end
      end
   endtask

   task automatic test_back_to_back();
      rst_n = 1'b0; en = 1'b0; #3; rst_n = 1'b1;
      en = 1'b1;
      for (int k = 1; k <= 255; k++) tick();
      checks++; if (addr1 !== 8'hFF) begin errors++; $display("FAIL b2b_pre got %h want ff", addr1); end
      load = 1'b1; incr = 16'h0200; offset = 8'h80;
      tick();
      load = 1'b0;
      checks++; if (addr1 !== 8'h00 || addr2 !== 8'h00 || wrap !== 1'b1 || pending !== 1'b0) begin
         errors++; $display("FAIL b2b_wrap got %h/%h/%b/%b want 00/00/1/0", addr1, addr2, wrap, pending);
      end
      tick();
      checks++; if (addr1 !== 8'h02 || addr2 !== 8'h82 || pending !== 1'b0) begin
         errors++; $display("FAIL b2b_step1 got %h/%h pend=%b want 02/82/0", addr1, addr2, pending);
      end
      tick();
      checks++; if (addr1 !== 8'h04 || addr2 !== 8'h84) begin
         errors++; $display("FAIL b2b_step2 got %h/%h want 04/84", addr1, addr2);
      end
   endtask

   task automatic test_async_reset();
      load = 1'b1; incr = 16'h0300; offset = 8'h10;
      tick();
      load = 1'b0;
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL ar_pend_set got %b want 1", pending); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (addr1 !== 8'h00 || addr2 !== 8'h00 || wrap !== 1'b0 || pending !== 1'b0) begin
         errors++; $display("FAIL ar_immediate got %h/%h/%b/%b want 00/00/0/0", addr1, addr2, wrap, pending);
      end
      @(negedge clk); rst_n = 1'b1; en = 1'b1;
      tick();
      checks++; if (addr1 !== 8'h01 || addr2 !== 8'h01 || pending !== 1'b0) begin
         errors++; $display("FAIL ar_step1 got %h/%h pend=%b want 01/01/0", addr1, addr2, pending);
      end
      tick();
      checks++; if (addr1 !== 8'h02) begin errors++; $display("FAIL ar_step2 got %h want 02", addr1); end
   endtask

   initial begin
      test_reset();
      test_default_step();
      test_stopped_load();
      test_phase_continuous();
      test_fractional();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
